// File: rtl/alu_core.sv
// rtl/alu_core.sv - registered WIDTH-bit ALU with eight bitwise/arithmetic ops
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   A, B       WIDTH-bit unsigned operands
//   ALU_Sel    3-bit operation select
//   in_valid   operands/opcode valid this cycle
//   ALU_Out    registered WIDTH-bit result
//   carry_out  registered carry (ADD) or no-borrow (SUB), 0 for logic ops
//   zero       registered flag, set when the loaded result is all zeros
//   out_valid  registered, high for the cycle after an accepted input
module alu_core #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             carry_out,
  output logic             zero,
  output logic             out_valid
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ADD  = 3'b110,
    OP_SUB  = 3'b111
  } op_e;

  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             valid_q;

  // Arithmetic is done one bit wider so the MSB carries out the carry/borrow.
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  assign sum_w  = {1'b0, A} + {1'b0, B};
  assign diff_w = {1'b0, A} - {1'b0, B};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_e'(ALU_Sel))
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NAND: alu_res = ~(A & B);
      OP_NOR:  alu_res = ~(A | B);
      OP_XNOR: alu_res = ~(A ^ B);
      OP_ADD: begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff_w[WIDTH-1:0];
        // The wide subtraction underflows into the MSB only when A < B.
        alu_carry = ~diff_w[WIDTH];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // Result and flags hold when no new input is accepted.
  always_comb begin
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (in_valid) begin
      res_d   = alu_res;
      carry_d = alu_carry;
      zero_d  = (alu_res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      valid_q <= in_valid;
    end
  end

  assign ALU_Out   = res_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - scoreboard bench for alu_core at WIDTH=1 and WIDTH=8
module tb_alu_core;

  typedef struct packed {
    logic [7:0] out;
    logic       c;
    logic       z;
  } exp_t;

  logic       clk;
  logic       rst;

  logic       a1, b1;
  logic [2:0] sel1;
  logic       v1;
  logic       out1, c1, z1, ov1;

  logic [7:0] a8, b8;
  logic [2:0] sel8;
  logic       v8;
  logic [7:0] out8;
  logic       c8, z8, ov8;

  exp_t q1[$];
  exp_t q8[$];

  int total;
  int bad;

  alu_core #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .ALU_Sel(sel1), .in_valid(v1),
    .ALU_Out(out1), .carry_out(c1), .zero(z1), .out_valid(ov1)
  );

  alu_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .ALU_Sel(sel8), .in_valid(v8),
    .ALU_Out(out8), .carry_out(c8), .zero(z8), .out_valid(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; sel1 = 3'b110; v1 = 1'b1;
    a8 = 8'hFF; b8 = 8'h01; sel8 = 3'b110; v8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({out1, c1, z1, ov1} !== 4'b0000) begin
      bad++; $display("FAIL reset_w1 got out/c/z/v=%b%b%b%b want 0000", out1, c1, z1, ov1);
    end
    total++; if ({out8, c8, z8, ov8} !== 11'd0) begin
      bad++; $display("FAIL reset_w8 got out=%h c=%b z=%b v=%b want 00 0 0 0", out8, c8, z8, ov8);
    end
    v1 = 1'b0; v8 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (ov1 !== 1'b0 || ov8 !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset got v1=%b v8=%b want 0 0", ov1, ov8);
    end
  endtask

  // outs/carries: bit i is the expected value for opcode i.
  task automatic test_sweep1(input logic a, input logic b,
                             input logic [7:0] outs, input logic [7:0] carries);
    exp_t e;
    for (int op = 0; op < 8; op++) begin
      a1 = a; b1 = b; sel1 = op[2:0]; v1 = 1'b1;
      e.out = {7'd0, outs[op]};
      e.c   = carries[op];
      e.z   = ~outs[op];
      q1.push_back(e);
      @(posedge clk); #1;
      total++; if (ov1 !== 1'b1) begin
        bad++; $display("FAIL sweep_valid a=%b b=%b op=%0d got %b want 1", a, b, op, ov1);
      end
      if (q1.size() == 0) begin
        total++; bad++; $display("FAIL sweep_queue a=%b b=%b op=%0d got empty want entry", a, b, op);
      end else begin
        e = q1.pop_front();
        total++; if (out1 !== e.out[0]) begin
          bad++; $display("FAIL sweep_out a=%b b=%b op=%0d got %b want %b", a, b, op, out1, e.out[0]);
        end
        total++; if (c1 !== e.c) begin
          bad++; $display("FAIL sweep_carry a=%b b=%b op=%0d got %b want %b", a, b, op, c1, e.c);
        end
        total++; if (z1 !== e.z) begin
          bad++; $display("FAIL sweep_zero a=%b b=%b op=%0d got %b want %b", a, b, op, z1, e.z);
        end
      end
    end
    v1 = 1'b0;
  endtask

  task automatic test_wide_hold();
    exp_t e;
    a8 = 8'hFF; b8 = 8'h01; sel8 = 3'b110; v8 = 1'b1;
    q8.push_back('{out: 8'h00, c: 1'b1, z: 1'b1});
    @(posedge clk); #1;
    e = q8.pop_front();
    total++; if ({out8, c8, z8, ov8} !== {e.out, e.c, e.z, 1'b1}) begin
      bad++; $display("FAIL add_wrap got out=%h c=%b z=%b v=%b want %h %b %b 1",
                      out8, c8, z8, ov8, e.out, e.c, e.z);
    end
    v8 = 1'b0; a8 = 8'h5A; b8 = 8'h33; sel8 = 3'b001;
    @(posedge clk); #1;
    total++; if ({out8, c8, z8, ov8} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL hold got out=%h c=%b z=%b v=%b want 00 1 1 0", out8, c8, z8, ov8);
    end
    a8 = 8'h10; b8 = 8'h20; sel8 = 3'b111; v8 = 1'b1;
    q8.push_back('{out: 8'hF0, c: 1'b0, z: 1'b0});
    @(posedge clk); #1;
    e = q8.pop_front();
    total++; if ({out8, c8, z8, ov8} !== {e.out, e.c, e.z, 1'b1}) begin
      bad++; $display("FAIL sub_borrow got out=%h c=%b z=%b v=%b want %h %b %b 1",
                      out8, c8, z8, ov8, e.out, e.c, e.z);
    end
    v8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    // Hand-computed 8-bit vectors: {A, B, op, out, carry}
    logic [7:0] va [6] = '{8'hC3, 8'hC3, 8'h80, 8'h20, 8'h55, 8'hF0};
    logic [7:0] vb [6] = '{8'h0F, 8'h0F, 8'h80, 8'h20, 8'hAA, 8'h0F};
    logic [2:0] vo [6] = '{3'b000, 3'b011, 3'b110, 3'b111, 3'b101, 3'b100};
    logic [7:0] vr [6] = '{8'h03, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       vc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      a8 = va[i]; b8 = vb[i]; sel8 = vo[i]; v8 = 1'b1;
      q8.push_back('{out: vr[i], c: vc[i], z: (vr[i] == 8'h00)});
      @(posedge clk); #1;
      e = q8.pop_front();
      total++; if ({out8, c8, z8, ov8} !== {e.out, e.c, e.z, 1'b1}) begin
        bad++; $display("FAIL b2b_%0d got out=%h c=%b z=%b v=%b want %h %b %b 1",
                        i, out8, c8, z8, ov8, e.out, e.c, e.z);
      end
    end
    v8 = 1'b0;
  endtask

  task automatic test_reset_discard();
    a8 = 8'h12; b8 = 8'h34; sel8 = 3'b001; v8 = 1'b1;
    @(posedge clk); #1;
    total++; if (out8 !== 8'h36 || ov8 !== 1'b1) begin
      bad++; $display("FAIL pre_reset_or got out=%h v=%b want 36 1", out8, ov8);
    end
    rst = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sel8 = 3'b110;
    @(posedge clk); #1;
    total++; if ({out8, c8, z8, ov8} !== 11'd0) begin
      bad++; $display("FAIL reset_discard got out=%h c=%b z=%b v=%b want 00 0 0 0", out8, c8, z8, ov8);
    end
    rst = 1'b0; v8 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; sel1 = 3'b000; v1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; sel8 = 3'b000; v8 = 1'b0;
    test_reset();
    test_sweep1(1'b0, 1'b0, 8'b0011_1000, 8'b1000_0000);
    test_sweep1(1'b0, 1'b1, 8'b1100_1110, 8'b0000_0000);
    test_sweep1(1'b1, 1'b0, 8'b1100_1110, 8'b1000_0000);
    test_sweep1(1'b1, 1'b1, 8'b0010_0011, 8'b1100_0000);
    test_wide_hold();
    test_back_to_back();
    test_reset_discard();
    total++; if (q1.size() != 0 || q8.size() != 0) begin
      bad++; $display("FAIL queue_drain got %0d/%0d want 0/0", q1.size(), q8.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
